ex_mem_stage: RTL and testbench

- EX/MEM boundary stage directly downstream of the ALU. Registers the ALU result and flags with control and store data, and hands them to the memory stage through a valid/ready handshake.
- Two-entry skid buffer, so ex_ready is a registered signal with no combinational path from mem_ready.
- Resolves conditional branches from ALU flags and emits a one-cycle redirect.
- Detects signed-overflow traps and holds a sticky exception until the controller acknowledges it.

---
 rtl/ex_mem_stage.sv | 181 ++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM stage: two-entry skid buffer toward MEM, branch redirect and sticky overflow exception.
// Optional: define EX_MEM_BLTZ_EN to make branch_type 2'b11 a BLTZ/BGEZ sign branch.
module ex_mem_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              zero_flag,
  input  logic              neg_flag,
  input  logic              overflow,
  input  logic              trap_on_ovf,
  input  logic [1:0]        branch_type,
  input  logic [DATA_W-1:0] branch_target,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [REG_W-1:0]  wsel_in,
  input  logic              regwrite_in,
  input  logic              memread_in,
  input  logic              memwrite_in,
  input  logic [DATA_W-1:0] store_data_in,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_W-1:0]  mem_wsel,
  output logic              mem_regwrite,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              exc_pending,
  output logic [DATA_W-1:0] epc,
  input  logic              exc_ack
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  wsel;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e            state_q, state_d;
  entry_t            head_q, head_d, skid_q, skid_d, new_entry;
  logic              ready_q, ready_d;
  logic              exc_q, exc_d;
  logic [DATA_W-1:0] epc_q, epc_d;
  logic              redirect_q, redirect_d;
  logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
  logic              accept, pop, taken, trap;

  assign accept = ex_valid & ready_q;
  assign pop    = mem_valid & mem_ready;
  assign trap   = accept & ~flush & trap_on_ovf & overflow;

  always_comb begin
    taken = 1'b0;
    case (branch_type)
      2'b01:   taken = zero_flag;
      2'b10:   taken = ~zero_flag;
`ifdef EX_MEM_BLTZ_EN
      2'b11:   taken = wsel_in[0] ? ~neg_flag : neg_flag;
`endif
      default: taken = 1'b0;
    endcase
  end

`ifndef EX_MEM_BLTZ_EN
  logic unused_neg;
  assign unused_neg = neg_flag;
`endif

  // A trapping instruction still flows to MEM but must not commit any side effect.
  always_comb begin
    new_entry.result     = alu_result;
    new_entry.store_data = store_data_in;
    new_entry.wsel       = wsel_in;
    new_entry.regwrite   = regwrite_in & ~(trap_on_ovf & overflow);
    new_entry.memread    = memread_in  & ~(trap_on_ovf & overflow);
    new_entry.memwrite   = memwrite_in & ~(trap_on_ovf & overflow);
  end

  // Occupancy FSM: state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= StEmpty;
    else     state_q <= state_d;
  end

  // Occupancy FSM: next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: if (accept) state_d = StOne;
        StOne: begin
          if (accept && !pop)      state_d = StTwo;
          else if (pop && !accept) state_d = StEmpty;
        end
        StTwo:   if (pop) state_d = StOne;
        default: state_d = StEmpty;
      endcase
    end
  end

  // Occupancy FSM: outputs
  always_comb begin
    mem_valid = (state_q != StEmpty);
  end

  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    if (!flush) begin
      case (state_q)
        StEmpty: if (accept) head_d = new_entry;
        StOne: begin
          if (accept && pop) head_d = new_entry;
          else if (accept)   skid_d = new_entry;
        end
        StTwo:   if (pop) head_d = skid_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    exc_d = exc_q;
    epc_d = epc_q;
    if (exc_ack) exc_d = 1'b0;
    if (trap) begin
      exc_d = 1'b1;
      epc_d = pc_plus4 - DATA_W'(4);
    end
    redirect_d    = accept & taken & ~flush;
    redirect_pc_d = redirect_d ? branch_target : '0;
    ready_d       = (state_d != StTwo) & ~exc_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q        <= '0;
      skid_q        <= '0;
      ready_q       <= 1'b0;
      exc_q         <= 1'b0;
      epc_q         <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      head_q        <= head_d;
      skid_q        <= skid_d;
      ready_q       <= ready_d;
      exc_q         <= exc_d;
      epc_q         <= epc_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign ex_ready       = ready_q;
  assign mem_result     = head_q.result;
  assign mem_store_data = head_q.store_data;
  assign mem_wsel       = head_q.wsel;
  assign mem_regwrite   = head_q.regwrite;
  assign mem_memread    = head_q.memread;
  assign mem_memwrite   = head_q.memwrite;
  assign redirect       = redirect_q;
  assign redirect_pc    = redirect_pc_q;
  assign exc_pending    = exc_q;
  assign epc            = epc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed steps then random traffic checked against a queue-based model.
module tb_ex_mem_stage;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic CLK = 1'b0;
  logic RST, flush, ex_valid, ex_ready, zero_flag, neg_flag, overflow, trap_on_ovf;
  logic [DATA_W-1:0] alu_result, branch_target, pc_plus4, store_data_in;
  logic [1:0] branch_type;
  logic [REG_W-1:0] wsel_in, mem_wsel;
  logic regwrite_in, memread_in, memwrite_in, mem_valid, mem_ready;
  logic [DATA_W-1:0] mem_result, mem_store_data, redirect_pc, epc;
  logic mem_regwrite, mem_memread, mem_memwrite, redirect, exc_pending, exc_ack;

  always #5 CLK = ~CLK;

  ex_mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .zero_flag(zero_flag), .neg_flag(neg_flag), .overflow(overflow),
    .trap_on_ovf(trap_on_ovf), .branch_type(branch_type), .branch_target(branch_target),
    .pc_plus4(pc_plus4), .wsel_in(wsel_in), .regwrite_in(regwrite_in),
    .memread_in(memread_in), .memwrite_in(memwrite_in), .store_data_in(store_data_in),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_result(mem_result),
    .mem_store_data(mem_store_data), .mem_wsel(mem_wsel), .mem_regwrite(mem_regwrite),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .redirect(redirect),
    .redirect_pc(redirect_pc), .exc_pending(exc_pending), .epc(epc), .exc_ack(exc_ack)
  );

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  wsel;
    logic rw, mr, mw;
  } ent_t;

  ent_t q[$];
  bit m_ready, m_exc, m_redir;
  logic [DATA_W-1:0] m_epc, m_rpc;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_taken();
    case (branch_type)
      2'd1: return zero_flag;
      2'd2: return !zero_flag;
`ifdef EX_MEM_BLTZ_EN
      2'd3: return wsel_in[0] ? !neg_flag : neg_flag;
`endif
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle();
    flush = 0; ex_valid = 0; alu_result = '0; zero_flag = 0; neg_flag = 0; overflow = 0;
    trap_on_ovf = 0; branch_type = 0; branch_target = '0; pc_plus4 = '0; wsel_in = '0;
    regwrite_in = 0; memread_in = 0; memwrite_in = 0; store_data_in = '0; mem_ready = 1;
    exc_ack = 0;
  endtask

  task automatic model_reset();
    q.delete(); m_ready = 0; m_exc = 0; m_redir = 0; m_epc = '0; m_rpc = '0;
  endtask

  // One clock: model the edge from the spec's rules, then compare every output.
  task automatic step();
    bit acc, pop, tk, trp;
    ent_t e;
    acc = ex_valid && m_ready;
    pop = (q.size() != 0) && mem_ready;
    tk  = m_taken();
    trp = trap_on_ovf && overflow;
    e   = '{alu_result, store_data_in, wsel_in,
            regwrite_in && !trp, memread_in && !trp, memwrite_in && !trp};
    @(posedge CLK); #1;
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    m_redir = acc && tk && !flush;
    m_rpc   = branch_target;
    if (exc_ack) m_exc = 0;
    if (acc && !flush && trp) begin
      m_exc = 1;
      m_epc = pc_plus4 - 32'd4;
    end
    m_ready = (q.size() < 2) && !m_exc;
    chk("ex_ready", ex_ready, m_ready);
    chk("mem_valid", mem_valid, q.size() != 0);
    if (q.size() != 0)
      chk("mem_head", {mem_result, mem_store_data, mem_wsel, mem_regwrite, mem_memread,
                       mem_memwrite}, q[0]);
    chk("redirect", redirect, m_redir);
    if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
    chk("exc_pending", exc_pending, m_exc);
    chk("epc", epc, m_epc);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {ex_ready, mem_valid, mem_result, mem_store_data, mem_wsel,
                         mem_regwrite, mem_memread, mem_memwrite, redirect, redirect_pc,
                         exc_pending, epc}, '0);
  endtask

  initial begin
    bit exp_bltz;
    RST = 1; idle(); model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    RST = 0;
    step();
    chk("ready_after_reset", ex_ready, 1'b1);

    // single accept, next-cycle visibility
    ex_valid = 1; alu_result = 32'hAA; wsel_in = 5'd3; regwrite_in = 1;
    step();
    chk("t1_result", mem_result, 32'hAA);
    chk("t1_wsel", mem_wsel, 5'd3);
    idle(); step();
    chk("t1_drain", mem_valid, 1'b0);

    // back-pressure: 1,2 accepted, 3 held, then drained in order
    mem_ready = 0; ex_valid = 1; regwrite_in = 1;
    alu_result = 1; step();
    alu_result = 2; step();
    chk("t2_full_ready", ex_ready, 1'b0);
    alu_result = 3; step();
    chk("t2_hold_head", mem_result, 32'd1);
    mem_ready = 1; step();
    chk("t2_out2", mem_result, 32'd2);
    step();
    chk("t2_out3", mem_result, 32'd3);
    idle(); step();
    chk("t2_empty", mem_valid, 1'b0);

    // BEQ taken, then BNE not taken
    ex_valid = 1; branch_type = 2'b01; zero_flag = 1; branch_target = 32'h40;
    step();
    chk("beq_redirect", redirect, 1'b1);
    chk("beq_pc", redirect_pc, 32'h40);
    branch_type = 2'b10; step();
    chk("bne_no_redirect", redirect, 1'b0);
    idle(); step();

    // overflow trap held until ack
    ex_valid = 1; trap_on_ovf = 1; overflow = 1; pc_plus4 = 32'h104; regwrite_in = 1;
    alu_result = 32'h7; step();
    chk("trap_exc", exc_pending, 1'b1);
    chk("trap_epc", epc, 32'h100);
    chk("trap_rw", mem_regwrite, 1'b0);
    chk("trap_ready", ex_ready, 1'b0);
    trap_on_ovf = 0; overflow = 0; step(); step();
    chk("trap_still", ex_ready, 1'b0);
    exc_ack = 1; step();
    chk("ack_ready", ex_ready, 1'b1);
    chk("ack_clear", exc_pending, 1'b0);
    idle(); step();

    // flush from TWO with a taken BEQ offered
    mem_ready = 0; ex_valid = 1; alu_result = 9; step(); alu_result = 10; step();
    flush = 1; branch_type = 2'b01; zero_flag = 1; branch_target = 32'h80; step();
    chk("flush_valid", mem_valid, 1'b0);
    chk("flush_redirect", redirect, 1'b0);
    chk("flush_ready", ex_ready, 1'b1);
    idle(); step();

    // sign branch encoding
    ex_valid = 1; branch_type = 2'b11; wsel_in = 5'd0; neg_flag = 1; branch_target = 32'hC0;
`ifdef EX_MEM_BLTZ_EN
    exp_bltz = 1;
`else
    exp_bltz = 0;
`endif
    step();
    chk("bltz_redirect", redirect, exp_bltz);
    idle(); step();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      flush         = ($urandom_range(0, 19) == 0);
      ex_valid      = ($urandom_range(0, 9) < 7);
      mem_ready     = ($urandom_range(0, 9) < 6);
      alu_result    = $urandom;
      store_data_in = $urandom;
      wsel_in       = REG_W'($urandom);
      regwrite_in   = $urandom_range(0, 1);
      memread_in    = $urandom_range(0, 1);
      memwrite_in   = $urandom_range(0, 1);
      zero_flag     = $urandom_range(0, 1);
      neg_flag      = $urandom_range(0, 1);
      branch_type   = 2'($urandom_range(0, 3));
      branch_target = $urandom;
      pc_plus4      = $urandom;
      trap_on_ovf   = ($urandom_range(0, 3) == 0);
      overflow      = $urandom_range(0, 1);
      exc_ack       = m_exc && ($urandom_range(0, 3) == 0);
      step();
      if (i == 300) begin
        // asynchronous reset mid-cycle clears everything at once
        #2 RST = 1; #1;
        chk_all_zero("async_reset");
        model_reset(); idle();
        @(posedge CLK); #1;
        RST = 0;
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
